timer_compare: RTL and testbench

- Programmable compare-match timer: free-running N-bit counter with prescaler; raises a match pulse and sticky interrupt when count equals a loaded compare value.
- Sits directly downstream of the structural equality comparator (comparator_eq, N-bit instance): it owns the count and compare registers feeding the comparator and consumes its out.
- Used for CPU timer interrupts and fixed-interval test stimulus.

---
 rtl/timer_pkg.sv | 13 +
 rtl/comparator_eq.sv | 12 +
 rtl/timer_prescaler.sv | 35 +++
 rtl/timer_compare.sv | 125 ++++++++++++
 tb/tb_timer_compare.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and default sizing for the compare-match timer.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRED = 2'd2
    } timer_state_t;

    localparam int TIMER_N_DEF          = 32;
    localparam int TIMER_PRESCALE_W_DEF = 8;

endpackage

// File: rtl/comparator_eq.sv
// N-bit structural equality comparator; purely combinational, no flow control.
module comparator_eq #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out
);

    assign out = (a == b);

endmodule

// File: rtl/timer_prescaler.sv
// Divides enabled cycles into ticks: tick is combinational in the cycle the divider reaches prescale.
// enable low freezes the divider; clear forces it back to zero at the next edge.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div_q, div_d;

    assign tick = enable && (div_q == prescale);

    always_comb begin
        div_d = div_q;
        if (clear || tick) begin
            div_d = '0;
        end else if (enable) begin
            div_d = div_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/timer_compare.sv
// Compare-match timer: prescaled counter, one-shot/periodic match with registered pulse and sticky irq.
// Outputs are registered one cycle after the matching tick; optional count capture under TIMER_CAPTURE_EN.
module timer_compare
    import timer_pkg::*;
#(
    parameter int N          = TIMER_N_DEF,
    parameter int PRESCALE_W = TIMER_PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  mode_periodic,
    input  logic                  cmp_valid,
    input  logic [N-1:0]          cmp_data,
    output logic                  cmp_ready,
    input  logic                  irq_clear,
    output logic [N-1:0]          count,
    output logic                  match_pulse,
    output logic                  irq_pending,
    output logic                  overflow
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic                  capture_strobe,
    output logic [N-1:0]          capture_value
`endif
);

    timer_state_t state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] cmp_q, cmp_d;
    logic         periodic_q, periodic_d;
    logic         match_pulse_q, irq_q, irq_d, ovf_q, ovf_d;

    logic tick, match, accept, fire, advance;

    // Gated by reset so a held cmp_valid is never seen as accepted while in reset.
    assign cmp_ready = rst && (state_q != S_ARMED);
    assign accept    = cmp_valid && cmp_ready;
    assign fire      = (state_q == S_ARMED) && tick && match;
    assign advance   = !accept && tick && !fire && (state_q != S_FIRED);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (accept),
        .prescale (prescale),
        .tick     (tick)
    );

    comparator_eq #(
        .N (N)
    ) u_cmp_eq (
        .a   (count_q),
        .b   (cmp_q),
        .out (match)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        periodic_d = periodic_q;
        if (accept) begin
            cmp_d      = cmp_data;
            periodic_d = mode_periodic;
            count_d    = '0;
            state_d    = S_ARMED;
        end else if (fire) begin
            if (periodic_q) begin
                count_d = '0;
            end else begin
                state_d = S_FIRED;
            end
        end else if (advance) begin
            count_d = count_q + N'(1);
        end
        irq_d = fire || (irq_q && !irq_clear);
        ovf_d = advance && (&count_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            cmp_q         <= '0;
            periodic_q    <= 1'b0;
            match_pulse_q <= 1'b0;
            irq_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            cmp_q         <= cmp_d;
            periodic_q    <= periodic_d;
            match_pulse_q <= fire;
            irq_q         <= irq_d;
            ovf_q         <= ovf_d;
        end
    end

    assign count       = count_q;
    assign match_pulse = match_pulse_q;
    assign irq_pending = irq_q;
    assign overflow    = ovf_q;

`ifdef TIMER_CAPTURE_EN
    logic [N-1:0] capture_q;

    // Samples the pre-edge count, so a strobe on a periodic restart sees the matched value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capture_q <= '0;
        end else if (capture_strobe) begin
            capture_q <= count_q;
        end
    end

    assign capture_value = capture_q;
`endif

endmodule

// File: tb/tb_timer_compare.sv
// Directed plus randomized checks of timer_compare against a tick-counting reference model.
module tb_timer_compare;

    localparam int N    = 4;
    localparam int PW   = 4;
    localparam int WRAP = 1 << N;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [PW-1:0] prescale;
    logic          mode_periodic;
    logic          cmp_valid;
    logic [N-1:0]  cmp_data;
    logic          cmp_ready;
    logic          irq_clear;
    logic [N-1:0]  count;
    logic          match_pulse;
    logic          irq_pending;
    logic          overflow;
`ifdef TIMER_CAPTURE_EN
    logic          capture_strobe;
    logic [N-1:0]  capture_value;
`endif

    timer_compare #(
        .N          (N),
        .PRESCALE_W (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .prescale      (prescale),
        .mode_periodic (mode_periodic),
        .cmp_valid     (cmp_valid),
        .cmp_data      (cmp_data),
        .cmp_ready     (cmp_ready),
        .irq_clear     (irq_clear),
        .count         (count),
        .match_pulse   (match_pulse),
        .irq_pending   (irq_pending),
        .overflow      (overflow)
`ifdef TIMER_CAPTURE_EN
        ,
        .capture_strobe(capture_strobe),
        .capture_value (capture_value)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: counts ticks since arm/reset and derives count arithmetically.
    bit m_armed, m_fired, m_per;
    int m_cmp, m_ticks, m_en;
    bit e_pulse, e_ovf, e_irq;
    int e_cap;

    function automatic int m_count();
        if (m_fired) return m_cmp;
        if (m_armed) return m_per ? (m_ticks % (m_cmp + 1)) : m_ticks;
        return m_ticks % WRAP;
    endfunction

    function automatic bit m_tick();
        int p;
        p = int'(prescale);
        return enable && ((m_en % (p + 1)) == p);
    endfunction

    function automatic bit m_fire_next();
        return m_armed && m_tick() && (m_count() == m_cmp);
    endfunction

    task automatic model_reset();
        m_armed = 0; m_fired = 0; m_per = 0;
        m_cmp = 0; m_ticks = 0; m_en = 0;
        e_pulse = 0; e_ovf = 0; e_irq = 0; e_cap = 0;
    endtask

    task automatic model_edge();
        int c;
        bit t, acc, fire;
        c    = m_count();
        t    = m_tick();
        acc  = cmp_valid && !m_armed;
        fire = m_armed && t && (c == m_cmp);
        e_pulse = fire;
        e_ovf   = !acc && !m_armed && !m_fired && t && (c == WRAP - 1);
        e_irq   = fire || (e_irq && !irq_clear);
`ifdef TIMER_CAPTURE_EN
        if (capture_strobe) e_cap = c;
`endif
        if (acc) begin
            m_cmp = int'(cmp_data); m_per = mode_periodic;
            m_armed = 1; m_fired = 0; m_ticks = 0; m_en = 0;
        end else begin
            if (enable) m_en++;
            if (fire && !m_per) begin
                m_armed = 0; m_fired = 1;
            end else if (t && !m_fired) begin
                m_ticks++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), m_count());
        chk("match_pulse", 32'(match_pulse), 32'(e_pulse));
        chk("irq_pending", 32'(irq_pending), 32'(e_irq));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("cmp_ready", 32'(cmp_ready), 32'(rst && !m_armed));
`ifdef TIMER_CAPTURE_EN
        chk("capture_value", 32'(capture_value), e_cap);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_pulse", 32'(match_pulse), 0);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        int n_p;
        int clr_phase;
        int q[$];

        rst = 1'b0; enable = 1'b0; prescale = '0; mode_periodic = 1'b0;
        cmp_valid = 1'b1; cmp_data = 4'd9; irq_clear = 1'b0;
`ifdef TIMER_CAPTURE_EN
        capture_strobe = 1'b0;
`endif
        model_reset();

        // Reset with a compare offered: never ready while held in reset.
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_ready", 32'(cmp_ready), 0);
        chk("rst_count", 32'(count), 0);
        cmp_valid = 1'b0; enable = 1'b1; prescale = '0; rst = 1'b1;
        #1;
        check_all();
        chk("idle_ready", 32'(cmp_ready), 1);

        // Idle free-run: wrap after 16 ticks, capture at count 7.
        for (int i = 1; i <= 20; i++) begin
`ifdef TIMER_CAPTURE_EN
            capture_strobe = (i == 8);
`endif
            step();
`ifdef TIMER_CAPTURE_EN
            if (i == 8) chk("capture7", 32'(capture_value), 7);
`endif
            if (i == 15) chk("ovf15", 32'(overflow), 0);
            if (i == 16) begin
                chk("ovf16", 32'(overflow), 1);
                chk("wrap_count", 32'(count), 0);
            end
        end
`ifdef TIMER_CAPTURE_EN
        capture_strobe = 1'b0;
`endif

        // One-shot compare at 5.
        cmp_valid = 1'b1; cmp_data = 4'd5; mode_periodic = 1'b0;
        step();
        cmp_valid = 1'b0;
        chk("arm_ready", 32'(cmp_ready), 0);
        n_p = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (match_pulse) n_p++;
            if (i == 6) chk("os_pulse6", 32'(match_pulse), 1);
        end
        chk("os_once", n_p, 1);
        chk("os_hold", 32'(count), 5);
        chk("os_irq", 32'(irq_pending), 1);
        chk("os_ready", 32'(cmp_ready), 1);

        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        chk("irq_cleared", 32'(irq_pending), 0);

        // Periodic compare at 3 with prescale 2, enable stall, ignored offers, set-vs-clear.
        prescale = 4'd2; cmp_data = 4'd3; mode_periodic = 1'b1; cmp_valid = 1'b1;
        step();
        clr_phase = 0;
        for (int i = 1; i <= 45; i++) begin
            enable    = !(i >= 14 && i <= 17);
            cmp_valid = (i >= 20 && i <= 22);
            cmp_data  = 4'd7;
            irq_clear = 1'b0;
            if (clr_phase == 0 && m_fire_next()) begin
                irq_clear = 1'b1; clr_phase = 1;
            end else if (clr_phase == 1) begin
                irq_clear = 1'b1; clr_phase = 2;
            end
            step();
            if (match_pulse) q.push_back(i);
            if (irq_clear && clr_phase == 1) chk("irq_set_wins", 32'(irq_pending), 1);
            if (irq_clear && clr_phase == 2) chk("irq_clear_alone", 32'(irq_pending), 0);
        end
        irq_clear = 1'b0; cmp_valid = 1'b0; enable = 1'b1;
        chk("per_pulses", q.size(), 3);
        if (q.size() >= 3) begin
            chk("per_first", q[0], 12);
            chk("per_stalled", q[1], 28);
            chk("per_third", q[2], 40);
        end

        // Reset mid-run, then compare at 0 periodic: match on every tick.
        do_reset();
        prescale = '0; cmp_data = '0; mode_periodic = 1'b1; cmp_valid = 1'b1;
        step();
        cmp_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("zero_every_tick", 32'(match_pulse), 1);
        end

        // Randomized rounds; prescale only changes across a reset.
        for (int r = 0; r < 25; r++) begin
            cmp_valid = 1'b0; irq_clear = 1'b0;
            prescale = PW'($urandom_range(0, 3));
            do_reset();
            for (int i = 0; i < 80; i++) begin
                enable        = ($urandom_range(0, 7) != 0);
                cmp_valid     = ($urandom_range(0, 9) == 0) || (i == 3);
                cmp_data      = N'($urandom_range(0, WRAP - 1));
                mode_periodic = $urandom_range(0, 1) == 1;
                irq_clear     = ($urandom_range(0, 7) == 0);
`ifdef TIMER_CAPTURE_EN
                capture_strobe = ($urandom_range(0, 5) == 0);
`endif
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
